// File: rtl/ps2_letter_rx_if.sv
// ==========================================================================
// ps2_letter_rx_if : PS/2 pin inputs and decoded letter outputs
// Rev 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

interface ps2_letter_rx_if;
  logic       kbdclk;
  logic       kbddat;
  logic [4:0] letter;
  logic       letter_valid;
  logic       frame_err;

  modport slave (
    input  kbdclk,
    input  kbddat,
    output letter,
    output letter_valid,
    output frame_err
  );

  modport master (
    output kbdclk,
    output kbddat,
    input  letter,
    input  letter_valid,
    input  frame_err
  );
endinterface

`default_nettype wire

// File: rtl/ps2_letter_rx.sv
// ==========================================================================
// ps2_letter_rx : PS/2 deframer + set-2 make/break decoder to 5-bit letters
// Optional parity rejection via PS2_PARITY_CHECK_EN.  Rev 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_letter_rx #(
  parameter int unsigned IDLE_TIMEOUT  = 20000,
  parameter logic [4:0]  RELEASE_CODE  = 5'd21,
  parameter logic [4:0]  UNMAPPED_CODE = 5'd30,
  parameter logic [4:0]  IDLE_CODE     = 5'd31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ps2_letter_rx_if.slave        bus
);

  localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_MAKE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  logic [1:0]        kclk_sync_q, kclk_sync_d;
  logic [1:0]        kdat_sync_q, kdat_sync_d;
  logic              kclk_last_q, kclk_last_d;
  logic              fall_q, fall_d;
  logic [10:0]       shift_q, shift_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  state_t            state_q, state_d;
  logic [4:0]        letter_q, letter_d;
  logic              letter_valid_q, letter_valid_d;
  logic              frame_err_q, frame_err_d;

  logic [10:0]       w_frame;
  logic              w_par_ok;
  logic              w_byte_ok;
  logic              w_frame_bad;
  logic [7:0]        w_byte;

  function automatic logic [4:0] letter_lut(input logic [7:0] code);
    case (code)
      8'h1C: letter_lut = 5'd0;   8'h32: letter_lut = 5'd1;
      8'h21: letter_lut = 5'd2;   8'h23: letter_lut = 5'd3;
      8'h24: letter_lut = 5'd4;   8'h2B: letter_lut = 5'd5;
      8'h34: letter_lut = 5'd6;   8'h33: letter_lut = 5'd7;
      8'h43: letter_lut = 5'd8;   8'h3B: letter_lut = 5'd9;
      8'h42: letter_lut = 5'd10;  8'h4B: letter_lut = 5'd11;
      8'h3A: letter_lut = 5'd12;  8'h31: letter_lut = 5'd13;
      8'h44: letter_lut = 5'd14;  8'h4D: letter_lut = 5'd15;
      8'h15: letter_lut = 5'd16;  8'h2D: letter_lut = 5'd17;
      8'h1B: letter_lut = 5'd18;  8'h2C: letter_lut = 5'd19;
      8'h3C: letter_lut = 5'd20;
      default: letter_lut = UNMAPPED_CODE;
    endcase
  endfunction

  // Incoming bit is shifted in at the top so the frame lands LSB-first.
  assign w_frame = {kdat_sync_q[1], shift_q[10:1]};
  assign w_byte  = w_frame[8:1];

`ifdef PS2_PARITY_CHECK_EN
  assign w_par_ok = ^w_frame[9:1];
`else
  assign w_par_ok = 1'b1;
`endif

  always_comb begin
    kclk_sync_d = {kclk_sync_q[0], bus.kbdclk};
    kdat_sync_d = {kdat_sync_q[0], bus.kbddat};
    kclk_last_d = kclk_sync_q[1];
    fall_d      = kclk_last_q & ~kclk_sync_q[1];
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    idle_d      = idle_q;
    w_byte_ok   = 1'b0;
    w_frame_bad = 1'b0;
    if (fall_q) begin
      idle_d  = '0;
      shift_d = w_frame;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        if (!w_frame[0] && w_frame[10] && w_par_ok) w_byte_ok = 1'b1;
        else                                        w_frame_bad = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (idle_q != IDLE_W'(IDLE_TIMEOUT)) begin
      idle_d = idle_q + IDLE_W'(1);
    end else if (bit_cnt_q != 4'd0) begin
      // Stalled partial frame is dropped quietly; decoder state is untouched.
      bit_cnt_d = 4'd0;
    end
  end

  always_comb begin
    state_d        = state_q;
    letter_d       = letter_q;
    letter_valid_d = 1'b0;
    frame_err_d    = w_frame_bad;
    if (w_byte_ok) begin
      case (state_q)
        ST_MAKE: begin
          if (w_byte == 8'hF0)      state_d = ST_BRK;
          else if (w_byte == 8'hE0) state_d = ST_EXT;
          else begin
            letter_d       = letter_lut(w_byte);
            letter_valid_d = 1'b1;
          end
        end
        ST_BRK: begin
          letter_d       = RELEASE_CODE;
          letter_valid_d = 1'b1;
          state_d        = ST_MAKE;
        end
        ST_EXT:  state_d = (w_byte == 8'hF0) ? ST_EXT_BRK : ST_MAKE;
        default: state_d = ST_MAKE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kclk_sync_q    <= 2'b11;
      kdat_sync_q    <= 2'b11;
      kclk_last_q    <= 1'b1;
      fall_q         <= 1'b0;
      shift_q        <= '0;
      bit_cnt_q      <= 4'd0;
      idle_q         <= '0;
      state_q        <= ST_MAKE;
      letter_q       <= IDLE_CODE;
      letter_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      kclk_sync_q    <= kclk_sync_d;
      kdat_sync_q    <= kdat_sync_d;
      kclk_last_q    <= kclk_last_d;
      fall_q         <= fall_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      idle_q         <= idle_d;
      state_q        <= state_d;
      letter_q       <= letter_d;
      letter_valid_q <= letter_valid_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign bus.letter       = letter_q;
  assign bus.letter_valid = letter_valid_q;
  assign bus.frame_err    = frame_err_q;

endmodule

`default_nettype wire
